// File: rtl/shift_seq_ctrl_if.sv
// Handshake and data bundle between the EX-stage requester and the
// multi-cycle shift controller.
interface shift_seq_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] num;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, num, shamt,
    input  busy, done, result
  );

  modport slave (
    input  start, op, num, shamt,
    output busy, done, result
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Iterative SLL/SRL/SRA shifter: one single-bit step per clock, busy for stall.
// Optional macro SHIFT_ROR_EN: op=11 rotates right instead of decoding as SRL.
module shift_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  shift_seq_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b10;
`ifdef SHIFT_ROR_EN
  localparam logic [1:0] OP_ROR = 2'b11;
`endif

  logic [1:0]       state;
  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] w_step;
  logic [SHW-1:0]   cnt;
  logic [1:0]       opr;

  always_comb begin
    w_step = {1'b0, w[WIDTH-1:1]};
    case (opr)
      OP_SLL:  w_step = {w[WIDTH-2:0], 1'b0};
      OP_SRA:  w_step = {w[WIDTH-1], w[WIDTH-1:1]};
`ifdef SHIFT_ROR_EN
      OP_ROR:  w_step = {w[0], w[WIDTH-1:1]};
`endif
      default: w_step = {1'b0, w[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      w     <= '0;
      cnt   <= '0;
      opr   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // DONE accepts a new start too, so requests can run back-to-back
          if (bus.start) begin
            w     <= bus.num;
            cnt   <= bus.shamt;
            opr   <= bus.op;
            state <= (bus.shamt == '0) ? DONE : SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          w   <= w_step;
          cnt <= cnt - 1'b1;
          if (cnt == SHW'(1)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = (state == SHIFT);
  assign bus.done   = (state == DONE);
  assign bus.result = w;

endmodule
